// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file geometry and the default scoreboard counter width.
package pipe_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned NREG      = 32;
    localparam int unsigned CNT_W_DEF = 2;

    typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// One per-register pending-writeback counter: up on issue, down on writeback, never wraps.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic one,
    output logic max
);

    logic [CNT_W-1:0] cnt;
    logic             dec_ok;

    // A writeback against an empty counter is an error reported by the parent; the count stays 0.
    assign dec_ok = dec & ~zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec_ok && !max) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_ok && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == CNT_W'(1));
    assign max  = &cnt;

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate between ID and EX; holds ID on RAW hazards or counter saturation.
// Optional SB_WB_BYPASS_EN: a retiring writeback releases its consumer in the same cycle.
module issue_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned NREG   = pipe_pkg::NREG,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  reg_idx_t          id_rs1,
    input  reg_idx_t          id_rs2,
    input  reg_idx_t          id_rd,
    input  logic              id_need_rs1,
    input  logic              id_need_rs2,
    input  logic              id_wb_en,
    input  logic              ex_ready,
    output logic              id_ready,
    input  logic              wb_valid,
    input  reg_idx_t          wb_rd,
    output logic              stall_raw,
    output logic              stall_full,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              sb_err
);

    logic [NREG-1:0] zero;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] full;
    logic            issue;
    logic            hz1;
    logic            hz2;
    logic            full_hit;
    logic            stall_cyc;

    // x0 is hardwired: never pending, never full.
    assign zero[0] = 1'b1;
    assign pend[0] = 1'b0;
    assign full[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic inc_r;
        logic dec_r;
        logic one_r;

        assign inc_r = issue & id_wb_en & (id_rd == REG_W'(r));
        assign dec_r = wb_valid & (wb_rd == REG_W'(r));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_r),
            .dec   (dec_r),
            .zero  (zero[r]),
            .one   (one_r),
            .max   (full[r])
        );

`ifdef SB_WB_BYPASS_EN
        assign pend[r] = ~zero[r] & ~(dec_r & one_r);
`else
        logic unused_one;
        assign unused_one = one_r;
        assign pend[r]    = ~zero[r];
`endif
    end

    assign hz1 = id_need_rs1 & pend[id_rs1];
    assign hz2 = id_need_rs2 & pend[id_rs2];

`ifdef SB_WB_BYPASS_EN
    assign full_hit = id_wb_en & full[id_rd] & ~(wb_valid & (wb_rd == id_rd));
`else
    assign full_hit = id_wb_en & full[id_rd];
`endif

    assign stall_raw  = id_valid & (hz1 | hz2);
    assign stall_full = id_valid & full_hit;
    assign id_ready   = ex_ready & ~stall_raw & ~stall_full;
    assign issue      = id_valid & id_ready;
    assign busy       = ~(&zero);

    // Only hazard stalls are counted; EX back-pressure is not.
    assign stall_cyc = id_valid & ex_ready & ~id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            sb_err    <= 1'b0;
        end else begin
            if (stall_cyc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (wb_valid && (wb_rd != '0) && zero[wb_rd]) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Vector-table bench for issue_scoreboard; expectations follow the build's SB_WB_BYPASS_EN setting.
module tb_issue_scoreboard;

    localparam int unsigned PW = 4;
`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_need_rs1, id_need_rs2, id_wb_en, ex_ready, wb_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd, wb_rd;
    logic          id_ready, stall_raw, stall_full, busy, sb_err;
    logic [PW-1:0] stall_cnt;

    issue_scoreboard #(.NREG(32), .CNT_W(2), .PERF_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_need_rs1 (id_need_rs1),
        .id_need_rs2 (id_need_rs2),
        .id_wb_en    (id_wb_en),
        .ex_ready    (ex_ready),
        .id_ready    (id_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall_raw   (stall_raw),
        .stall_full  (stall_full),
        .busy        (busy),
        .stall_cnt   (stall_cnt),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       n1, n2, wb, exr, wbv;
        logic [4:0] wbrd;
        logic       rdy, raw, full, bsy, err;
        logic [3:0] scnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input int rst, input int v, input int rs1, input int rs2, input int rd,
                                input int n1, input int n2, input int wb, input int exr,
                                input int wbv, input int wbrd, input int rdy, input int raw,
                                input int full, input int bsy, input int err, input int scnt);
        vec_t t;
        t.rst = 1'(rst);  t.v = 1'(v);
        t.rs1 = 5'(rs1);  t.rs2 = 5'(rs2); t.rd = 5'(rd);
        t.n1 = 1'(n1);    t.n2 = 1'(n2);   t.wb = 1'(wb);
        t.exr = 1'(exr);  t.wbv = 1'(wbv); t.wbrd = 5'(wbrd);
        t.rdy = 1'(rdy);  t.raw = 1'(raw); t.full = 1'(full);
        t.bsy = 1'(bsy);  t.err = 1'(err); t.scnt = 4'(scnt);
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h, want %0h", name, row, act, want);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v;     id_rs1 = t.rs1;     id_rs2 = t.rs2;  id_rd = t.rd;
        id_need_rs1 = t.n1; id_need_rs2 = t.n2; id_wb_en = t.wb; ex_ready = t.exr;
        wb_valid = t.wbv;   wb_rd = t.wbrd;
    endtask

    // Async reset pulse mid-cycle; state must clear before any clock edge.
    task automatic do_reset(input int row);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", row, 32'(busy), 32'd0);
        chk("rst_scnt", row, 32'(stall_cnt), 32'd0);
        chk("rst_err",  row, 32'(sb_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t t, e;
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_need_rs1 = 0; id_need_rs2 = 0;
        id_wb_en = 0; ex_ready = 1; wb_valid = 0; wb_rd = 0;

        // Reset state
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0, 0, 0,0,  0,0,0,0,0, 0);
        // Dependent chain: addi x5, then add x6,x5,x0
        add(0, 1,0,0,5, 1,0,1, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 1,5,0,6, 1,1,1, 1, 0,0,  0,1,0,1,0, 0);
        add(0, 1,5,0,6, 1,1,1, 1, 0,0,  0,1,0,1,0, 1);
        add(0, 1,5,0,6, 1,1,1, 1, 1,5,  BYP ? 1 : 0, BYP ? 0 : 1, 0,1,0, 2);
        add(0, BYP ? 0 : 1,5,0,6, 1,1,1, 1, 0,0,  1,0,0, BYP ? 1 : 0, 0, BYP ? 2 : 3);
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,1,0, BYP ? 2 : 3);
        // x0 handling
        add(1, 1,0,0,0, 1,0,1, 1, 0,0,  1,0,0,0,0, 0);
        for (int k = 0; k < 3; k++) add(0, 1,0,0,0, 1,0,1, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 1,0,0,1, 1,1,0, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,0,0, 0);
        // Saturation on x7
        add(1, 1,0,0,7, 0,0,1, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 1,0,0,7, 0,0,1, 1, 0,0,  1,0,0,1,0, 0);
        add(0, 1,0,0,7, 0,0,1, 1, 0,0,  1,0,0,1,0, 0);
        add(0, 1,0,0,7, 0,0,1, 1, 0,0,  0,0,1,1,0, 0);
        add(0, 1,0,0,7, 0,0,1, 0, 0,0,  0,0,1,1,0, 1);
        add(0, 1,0,0,7, 0,0,1, 1, 1,7,  BYP ? 1 : 0, 0, BYP ? 0 : 1, 1,0, 1);
        add(0, 1,0,0,7, 0,0,1, 1, 0,0,  BYP ? 0 : 1, 0, BYP ? 1 : 0, 1,0, BYP ? 1 : 2);
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,1,0, 2);
        // Simultaneous issue and writeback on x9
        add(1, 1,0,0,9, 0,0,1, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 1,0,0,9, 0,0,1, 1, 1,9,  1,0,0,1,0, 0);
        add(0, 1,9,0,0, 1,0,0, 1, 0,0,  0,1,0,1,0, 0);
        add(0, 0,0,0,0, 0,0,0, 1, 1,9,  1,0,0,1,0, 1);
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,0,0, 1);
        // Illegal writeback (x0 writeback is ignored first)
        add(0, 0,0,0,0, 0,0,0, 1, 1,0,  1,0,0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0, 1, 1,12, 1,0,0,0,0, 1);
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,0,1, 1);
        add(0, 1,12,0,0, 1,0,0, 1, 0,0, 1,0,0,0,1, 1);
        add(0, 0,0,0,0, 0,0,0, 1, 1,0,  1,0,0,0,1, 1);
        // Reset mid-flight with x3/x4 pending, error set and five stall cycles
        add(1, 1,0,0,3, 0,0,1, 1, 0,0,  1,0,0,0,0, 0);
        add(0, 1,0,0,4, 0,0,1, 1, 0,0,  1,0,0,1,0, 0);
        add(0, 0,0,0,0, 0,0,0, 1, 1,20, 1,0,0,1,0, 0);
        add(0, 1,0,4,0, 0,0,0, 1, 0,0,  1,0,0,1,1, 0);
        add(0, 1,0,4,0, 0,1,0, 1, 0,0,  0,1,0,1,1, 0);
        for (int k = 1; k < 5; k++) add(0, 1,3,0,0, 1,0,0, 1, 0,0,  0,1,0,1,1, k);
        add(0, 0,0,0,0, 0,0,0, 1, 0,0,  1,0,0,1,1, 5);
        add(1, 1,3,0,0, 1,0,0, 0, 0,0,  0,0,0,0,0, 0);
        add(0, 1,4,0,0, 1,0,0, 1, 0,0,  1,0,0,0,0, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            if (t.rst) do_reset(i);
            drive(t);
            exp_q.push_back(t);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("id_ready",   i, 32'(id_ready),   32'(e.rdy));
            chk("stall_raw",  i, 32'(stall_raw),  32'(e.raw));
            chk("stall_full", i, 32'(stall_full), 32'(e.full));
            chk("busy",       i, 32'(busy),       32'(e.bsy));
            chk("sb_err",     i, 32'(sb_err),     32'(e.err));
            chk("stall_cnt",  i, 32'(stall_cnt),  32'(e.scnt));
            @(posedge clk);
            #1;
        end

        // Perf counter saturates at all-ones under a long RAW stall on x2
        do_reset(1000);
        id_valid = 1; id_rd = 5'd2; id_wb_en = 1; id_need_rs1 = 0; id_need_rs2 = 0;
        ex_ready = 1; wb_valid = 0;
        @(posedge clk);
        #1;
        id_rs1 = 5'd2; id_need_rs1 = 1; id_rd = 5'd0; id_wb_en = 0;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back('{rst: 0, v: 1, rs1: 2, rs2: 0, rd: 0, n1: 1, n2: 0, wb: 0,
                              exr: 1, wbv: 0, wbrd: 0, rdy: 0, raw: 1, full: 0, bsy: 1,
                              err: 0, scnt: 4'((k > 15) ? 15 : k)});
            @(negedge clk);
            e = exp_q.pop_front();
            chk("sat_raw",  1001 + k, 32'(stall_raw), 32'(e.raw));
            chk("sat_scnt", 1001 + k, 32'(stall_cnt), 32'(e.scnt));
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
